// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare function codes, FCLASS bit positions,
// the decoded-operand record and the record held per buffered request.
package fpu_pkg;

    typedef enum logic [1:0] {
        FUNC_FLE  = 2'b00,
        FUNC_FLT  = 2'b01,
        FUNC_FEQ  = 2'b10,
        FUNC_RSVD = 2'b11
    } func_e;

    // RISC-V FCLASS result bit positions
    localparam int FC_NEG_INF  = 0;
    localparam int FC_NEG_NORM = 1;
    localparam int FC_NEG_SUB  = 2;
    localparam int FC_NEG_ZERO = 3;
    localparam int FC_POS_ZERO = 4;
    localparam int FC_POS_SUB  = 5;
    localparam int FC_POS_NORM = 6;
    localparam int FC_POS_INF  = 7;
    localparam int FC_SNAN     = 8;
    localparam int FC_QNAN     = 9;

    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        nan;
        logic        snan;
    } operand_t;

    // One buffered comparator request, already canonicalised and ordered
    typedef struct packed {
        func_e       func;
        logic        sign_a;
        logic        sign_b;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [23:0] sig_a;
        logic [23:0] sig_b;
        logic        nan_a;
        logic        nan_b;
        logic        signaling;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fill_e;

endpackage

// File: rtl/fpu_cmp_unpack_if.sv
// Request/response bundle of the compare-unpack stage.
interface fpu_cmp_unpack_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [1:0]  func_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  comp_func_o;
    logic        sign_a_o;
    logic        sign_b_o;
    logic [7:0]  exp_a_o;
    logic [7:0]  exp_b_o;
    logic [23:0] sig_a_o;
    logic [23:0] sig_b_o;
    logic        nan_a_o;
    logic        nan_b_o;
    logic        signaling_o;
    logic [9:0]  fclass_a_o;

    modport master (
        output in_valid_i, rs1_i, rs2_i, func_i, out_ready_i,
        input  in_ready_o, out_valid_o, comp_func_o, sign_a_o, sign_b_o,
               exp_a_o, exp_b_o, sig_a_o, sig_b_o, nan_a_o, nan_b_o,
               signaling_o, fclass_a_o
    );

    modport slave (
        input  in_valid_i, rs1_i, rs2_i, func_i, out_ready_i,
        output in_ready_o, out_valid_o, comp_func_o, sign_a_o, sign_b_o,
               exp_a_o, exp_b_o, sig_a_o, sig_b_o, nan_a_o, nan_b_o,
               signaling_o, fclass_a_o
    );
endinterface

// File: rtl/fpu_operand_decode.sv
// Combinational unpack of one IEEE-754 single operand. Zeros come out with
// sign 0 so +0/-0 compare equal downstream. The FCLASS output exists only
// when FPU_CMP_UNPACK_FCLASS_EN is defined and classifies the raw encoding.
module fpu_operand_decode
    import fpu_pkg::*;
(
    input  logic [31:0] x,
`ifdef FPU_CMP_UNPACK_FCLASS_EN
    output logic [9:0]  fclass,
`endif
    output operand_t    op
);
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        exp_max, exp_zero, frac_zero;

    assign exp       = x[30:23];
    assign frac      = x[22:0];
    assign exp_max   = (exp == 8'hFF);
    assign exp_zero  = (exp == 8'h00);
    assign frac_zero = (frac == 23'd0);

    // field extraction with zero-sign canonicalisation
    always_comb begin
        op.sign = x[31] & ~(exp_zero & frac_zero);
        op.exp  = exp;
        op.sig  = {~exp_zero, frac};
        op.nan  = exp_max & ~frac_zero;
        op.snan = exp_max & ~frac_zero & ~frac[22];
    end

`ifdef FPU_CMP_UNPACK_FCLASS_EN
    // one-hot class of the original encoding
    always_comb begin
        fclass = '0;
        if (exp_max && !frac_zero)      fclass[frac[22] ? FC_QNAN : FC_SNAN] = 1'b1;
        else if (exp_max)               fclass[x[31] ? FC_NEG_INF  : FC_POS_INF]  = 1'b1;
        else if (exp_zero && frac_zero) fclass[x[31] ? FC_NEG_ZERO : FC_POS_ZERO] = 1'b1;
        else if (exp_zero)              fclass[x[31] ? FC_NEG_SUB  : FC_POS_SUB]  = 1'b1;
        else                            fclass[x[31] ? FC_NEG_NORM : FC_POS_NORM] = 1'b1;
    end
`endif
endmodule

// File: rtl/fpu_cmp_unpack.sv
// Compare-operand unpack stage: decodes rs1/rs2, orders two negative operands
// so a magnitude compare gives the value order, and buffers results in a
// 2-entry main+skid FIFO with a registered in_ready_o.
// Optional: FPU_CMP_UNPACK_FCLASS_EN adds the FCLASS mask of rs1 per entry.
module fpu_cmp_unpack
    import fpu_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    fpu_cmp_unpack_if.slave  bus
);
    logic [NUM_OPS-1:0][31:0] rs;
    operand_t                 dec [NUM_OPS];
    operand_t                 oa, ob;
    logic                     swap;
    entry_t                   new_e, main_q, main_d, skid_q, skid_d;
    fill_e                    state_q, state_d;
    logic                     ready_q, push, pop;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
    logic [NUM_OPS-1:0][9:0]  fc_dec;
    logic [9:0]               fc_main_q, fc_main_d, fc_skid_q, fc_skid_d;
`endif

    assign rs = {bus.rs2_i, bus.rs1_i};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_dec
        fpu_operand_decode u_dec (
            .x      (rs[g]),
`ifdef FPU_CMP_UNPACK_FCLASS_EN
            .fclass (fc_dec[g]),
`endif
            .op     (dec[g])
        );
    end

    // swap both-negative pairs and assemble the entry to store
    always_comb begin
        swap            = dec[0].sign & dec[1].sign;
        oa              = swap ? dec[1] : dec[0];
        ob              = swap ? dec[0] : dec[1];
        new_e.func      = func_e'(bus.func_i);
        new_e.sign_a    = oa.sign;
        new_e.sign_b    = ob.sign;
        new_e.exp_a     = oa.exp;
        new_e.exp_b     = ob.exp;
        new_e.sig_a     = oa.sig;
        new_e.sig_b     = ob.sig;
        new_e.nan_a     = oa.nan;
        new_e.nan_b     = ob.nan;
        new_e.signaling = oa.snan | ob.snan;
    end

    assign push = bus.in_valid_i & ready_q;
    assign pop  = (state_q != ST_EMPTY) & bus.out_ready_i;

    // FIFO fill state and entry movement; main always holds the oldest entry
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
        fc_main_d = fc_main_q;
        fc_skid_d = fc_skid_q;
`endif
        case (state_q)
            ST_EMPTY: if (push) begin
                main_d  = new_e;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
                fc_main_d = fc_dec[0];
`endif
                state_d = ST_ONE;
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = new_e;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
                    fc_main_d = fc_dec[0];
`endif
                end else if (push) begin
                    skid_d  = new_e;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
                    fc_skid_d = fc_dec[0];
`endif
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            default: if (pop) begin
                main_d  = skid_q;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
                fc_main_d = fc_skid_q;
`endif
                state_d = ST_ONE;
            end
        endcase
    end

    // state registers; ready is registered from the next fill level
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
            fc_main_q <= '0;
            fc_skid_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            main_q  <= main_d;
            skid_q  <= skid_d;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
            fc_main_q <= fc_main_d;
            fc_skid_q <= fc_skid_d;
`endif
        end
    end

    assign bus.in_ready_o  = ready_q;
    assign bus.out_valid_o = (state_q != ST_EMPTY);
    assign bus.comp_func_o = main_q.func;
    assign bus.sign_a_o    = main_q.sign_a;
    assign bus.sign_b_o    = main_q.sign_b;
    assign bus.exp_a_o     = main_q.exp_a;
    assign bus.exp_b_o     = main_q.exp_b;
    assign bus.sig_a_o     = main_q.sig_a;
    assign bus.sig_b_o     = main_q.sig_b;
    assign bus.nan_a_o     = main_q.nan_a;
    assign bus.nan_b_o     = main_q.nan_b;
    assign bus.signaling_o = main_q.signaling;
`ifdef FPU_CMP_UNPACK_FCLASS_EN
    assign bus.fclass_a_o  = fc_main_q;
`else
    assign bus.fclass_a_o  = '0;
`endif
endmodule

// File: doc/fpu_cmp_unpack.md
FPU_CMP_UNPACK -- requirements
Module: fpu_cmp_unpack

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port in_valid_i, input, 1 bit: request present.
REQ-004 SHALL have port in_ready_o, output, 1 bit: block accepts request this cycle.
REQ-005 SHALL have port rs1_i, input, 32 bits: IEEE-754 single operand A.
REQ-006 SHALL have port rs2_i, input, 32 bits: IEEE-754 single operand B.
REQ-007 SHALL have port func_i, input, 2 bits: 00 FLE, 01 FLT, 10 FEQ, 11 reserved.
REQ-008 SHALL have port out_valid_o, output, 1 bit: unpacked fields valid.
REQ-009 SHALL have port out_ready_i, input, 1 bit: downstream comparator stage consumes.
REQ-010 SHALL have outputs comp_func_o (2), sign_a_o, sign_b_o (1 each), exp_a_o, exp_b_o (8 each), sig_a_o, sig_b_o (24 each), nan_a_o, nan_b_o, signaling_o (1 each): comparator operand bundle.
REQ-011 SHALL have output fclass_a_o, 10 bits: RISC-V FCLASS mask of rs1 (see Configuration).

Function
REQ-012 Transfer in/out SHALL occur when valid and ready are both high in the same cycle.
REQ-013 Latency SHALL be exactly 1 cycle from accepted input to out_valid_o with empty buffer.
REQ-014 Storage SHALL be a 2-entry FIFO (main + skid); order preserved; no bubble at full throughput.
REQ-015 in_ready_o SHALL be registered: high iff fewer than 2 entries held, or 2 held and out_ready_i high is not used (no combinational ready path).
REQ-016 Simultaneous accept and consume with 1 entry held SHALL keep count 1, replacing the entry.
REQ-017 Accept with 2 entries held SHALL be impossible; in_valid_i is ignored while in_ready_o low.
REQ-018 Per operand: sign = bit31, exp = bits30:23, sig = {|exp, bits22:0} (hidden bit 0 for zero/subnormal).
REQ-019 nan_x = (exp==0xFF) and frac!=0; signaling_o = OR over NaN operands of (bit22==0).
REQ-020 Zero canonicalisation: operand with exp==0 and frac==0 SHALL output sign 0.
REQ-021 If both canonical signs are 1, A and B fields (sign, exp, sig, nan) SHALL be swapped so magnitude-less equals value-less.
REQ-022 func_i==11 SHALL be passed through unchanged; no other effect.

Reset
REQ-023 While reset_i low at a clock edge: entry count 0, out_valid_o 0, in_ready_o 0; all data outputs 0.
REQ-024 in_ready_o SHALL rise the first cycle after reset_i deasserts; reset mid-transfer drops all held entries.

Configuration
REQ-025 Macro FPU_CMP_UNPACK_FCLASS_EN defined: fclass_a_o carries the 10-bit FCLASS of the original (unswapped, uncanonicalised) rs1, stored with the entry.
REQ-026 Macro undefined: fclass_a_o tied 0, no FCLASS storage.

Structure
REQ-027 Shared package fpu_pkg SHALL hold: func encodings (FLE/FLT/FEQ), FCLASS bit indices, unpacked-operand struct (sign, exp, sig, nan, snan).
REQ-028 Sub-module fpu_operand_decode (combinational, one per operand) SHALL perform REQ-018..020 and FCLASS.

Verification
REQ-029 FLT rs1=0x3F800000, rs2=0x40000000 -> next cycle out_valid_o=1, exp_a=0x7F, exp_b=0x80, sig_a=sig_b=0x800000, signs 0.
REQ-030 FEQ rs1=0x00000000, rs2=0x80000000 -> sign_a=sign_b=0, exp 0, sig 0, nan 0.
REQ-031 FLT rs1=0xBF800000, rs2=0xC0000000 -> swapped: exp_a=0x80, exp_b=0x7F, signs 1.
REQ-032 FEQ rs1=0x7F800001, rs2=0x7FC00000 -> nan_a=nan_b=1, signaling_o=1; fclass_a_o=0x100 with macro, 0 without.
REQ-033 out_ready_i=0, 3 back-to-back requests -> 2 accepted, in_ready_o low from cycle after 2nd, 3rd held off; release -> outputs in order, one per cycle.
REQ-034 reset_i low with 2 entries held -> next cycle out_valid_o=0, outputs 0; in_ready_o=1 one cycle after release.
